// File: rtl/clock_divider_n.sv
// Multi-channel programmable clock divider: per-channel divided clock, end-of-period tick
// and run status, with divisor/enable changes taking effect only at period boundaries.
module clock_divider_n #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       div_load,
    input  logic [CHANNELS*DIV_W-1:0] div_value,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       active
);

    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST = (DEFAULT_DIV < 2) ? DIV_MIN : DIV_W'(DEFAULT_DIV);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Divisors below 2 cannot form a high and a low phase, so they are raised to 2.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        state_t           state_q;
        state_t           state_n;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_n;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_n;
        logic [DIV_W-1:0] pend_q;
        logic [DIV_W-1:0] pend_n;
        logic             pv_q;
        logic             pv_n;
        logic             clk_out_q;
        logic             tick_q;
        logic             active_q;
        logic [DIV_W-1:0] load_val;
        logic             wrap;

        assign load_val = clamp_div(div_value[g*DIV_W +: DIV_W]);
        assign wrap     = (cnt_q == div_q - DIV_W'(1));

        // State and counter registers; outputs are decoded from the next-cycle values.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                div_q     <= DIV_RST;
                pend_q    <= DIV_RST;
                pv_q      <= 1'b0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
                active_q  <= 1'b0;
            end else begin
                state_q   <= state_n;
                cnt_q     <= cnt_n;
                div_q     <= div_n;
                pend_q    <= pend_n;
                pv_q      <= pv_n;
                clk_out_q <= (state_n == ST_RUN) && (cnt_n < (div_n >> 1));
                tick_q    <= (state_n == ST_RUN) && (cnt_n == div_n - DIV_W'(1));
                active_q  <= (state_n == ST_RUN);
            end
        end

        // Next state: wrap and sync are a single boundary where pending divisor and enable apply.
        always_comb begin
            state_n = state_q;
            cnt_n   = cnt_q;
            div_n   = div_q;
            pend_n  = pend_q;
            pv_n    = pv_q;
            case (state_q)
                ST_IDLE: begin
                    cnt_n = '0;
                    if (div_load[g]) begin
                        div_n  = load_val;
                        pend_n = load_val;
                        pv_n   = 1'b0;
                    end else if (enable[g] && pv_q) begin
                        div_n = pend_q;
                        pv_n  = 1'b0;
                    end
                    if (enable[g]) begin
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wrap || sync) begin
                        cnt_n = '0;
                        if (pv_q) begin
                            div_n = pend_q;
                            pv_n  = 1'b0;
                        end
                        if (!enable[g]) begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        cnt_n = cnt_q + DIV_W'(1);
                    end
                    // A load on the boundary edge queues behind the value applied now.
                    if (div_load[g]) begin
                        pend_n = load_val;
                        pv_n   = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        assign clk_out[g] = clk_out_q;
        assign tick[g]    = tick_q;
        assign active[g]  = active_q;
    end

endmodule

// File: tb/tb_clock_divider_n.sv
// Scoreboard bench for clock_divider_n: directed per-cycle stimulus pushes hand-computed
// expected outputs; a negedge monitor pops and compares them.
module tb_clock_divider_n;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    enable;
    logic [CH-1:0]    div_load;
    logic [CH*DW-1:0] div_value;
    logic             sync;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    active;

    always #5 clk = ~clk;

    clock_divider_n #(
        .CHANNELS   (CH),
        .DIV_W      (DW),
        .DEFAULT_DIV(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .div_load (div_load),
        .div_value(div_value),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .active   (active)
    );

    typedef struct {
        logic [CH-1:0] ck;
        logic [CH-1:0] tk;
        logic [CH-1:0] ac;
        int            tid;
        int            sid;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;
    int            tid      = 0;
    int            sid      = 0;

    logic          rst_v;
    logic [CH-1:0] en_v;
    logic [CH-1:0] ld_v;
    logic [DW-1:0] dv_v[CH];
    logic          sync_v;

    // Ideal waveform of one period position: {clk_out, tick}.
    function automatic logic [1:0] wv(input int d, input int ph);
        return {ph < d / 2, ph == d - 1};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic [CH-1:0] ck, input logic [CH-1:0] tk, input logic [CH-1:0] ac);
        exp_t e;
        @(negedge clk);
        #1;
        rst      = rst_v;
        enable   = en_v;
        div_load = ld_v;
        sync     = sync_v;
        for (int k = 0; k < int'(CH); k++) div_value[k*DW +: DW] = dv_v[k];
        e.ck  = ck;
        e.tk  = tk;
        e.ac  = ac;
        e.tid = tid;
        e.sid = sid;
        sid++;
        q.push_back(e);
    endtask

    task automatic idle();
        step('0, '0, '0);
    endtask

    task automatic step1(input int ch, input int d, input int ph);
        logic [1:0]    w;
        logic [CH-1:0] ck;
        logic [CH-1:0] tk;
        logic [CH-1:0] ac;
        w      = wv(d, ph);
        ck     = '0;
        tk     = '0;
        ac     = '0;
        ck[ch] = w[1];
        tk[ch] = w[0];
        ac[ch] = 1'b1;
        step(ck, tk, ac);
    endtask

    // Channels 2 and 3 running together.
    task automatic step2(input int d2, input int ph2, input int d3, input int ph3);
        logic [1:0] w2;
        logic [1:0] w3;
        w2 = wv(d2, ph2);
        w3 = wv(d3, ph3);
        step({w3[1], w2[1], 2'b00}, {w3[0], w2[0], 2'b00}, 4'b1100);
    endtask

    // Monitor: every sampled cycle with a queued expectation is one comparison.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({clk_out, tick, active} !== {e.ck, e.tk, e.ac}) begin
                    failures++;
                    $display("FAIL test%0d step%0d clk_out=%b tick=%b active=%b expected clk_out=%b tick=%b active=%b",
                             e.tid, e.sid, clk_out, tick, active, e.ck, e.tk, e.ac);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = '0;
        div_load  = '0;
        div_value = '0;
        sync      = 1'b0;
        rst_v     = 1'b1;
        en_v      = '0;
        ld_v      = '0;
        sync_v    = 1'b0;
        for (int k = 0; k < int'(CH); k++) dv_v[k] = '0;

        // Reset state.
        tid = 0;
        idle();
        idle();
        rst_v = 1'b0;

        // Channel 0 with default divisor 2.
        tid = 1;
        en_v[0] = 1'b1;
        for (int i = 0; i < 6; i++) step1(0, 2, i % 2);
        en_v[0] = 1'b0;
        idle();
        idle();

        // Channel 1 loaded with 5 while idle.
        tid = 2;
        ld_v[1] = 1'b1;
        dv_v[1] = 16'd5;
        idle();
        ld_v[1] = 1'b0;
        en_v[1] = 1'b1;
        for (int i = 0; i < 10; i++) step1(1, 5, i % 5);
        en_v[1] = 1'b0;
        idle();

        // Channel 2: D=4, load 6 mid-period, load 3 on the wrap edge.
        tid = 3;
        ld_v[2] = 1'b1;
        dv_v[2] = 16'd4;
        idle();
        ld_v[2] = 1'b0;
        en_v[2] = 1'b1;
        step1(2, 4, 0);
        step1(2, 4, 1);
        ld_v[2] = 1'b1;
        dv_v[2] = 16'd6;
        step1(2, 4, 2);
        ld_v[2] = 1'b0;
        step1(2, 4, 3);
        ld_v[2] = 1'b1;
        dv_v[2] = 16'd3;
        step1(2, 6, 0);
        ld_v[2] = 1'b0;
        for (int i = 1; i < 6; i++) step1(2, 6, i);
        for (int i = 0; i < 6; i++) step1(2, 3, i % 3);
        en_v[2] = 1'b0;
        idle();

        // Channel 0: D=8, enable dropped mid-period, then a drop/reassert within one period.
        tid = 4;
        ld_v[0] = 1'b1;
        dv_v[0] = 16'd8;
        idle();
        ld_v[0] = 1'b0;
        en_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) step1(0, 8, i);
        en_v[0] = 1'b0;
        for (int i = 3; i < 8; i++) step1(0, 8, i);
        idle();
        idle();
        en_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) step1(0, 8, i);
        en_v[0] = 1'b0;
        step1(0, 8, 3);
        step1(0, 8, 4);
        en_v[0] = 1'b1;
        for (int i = 5; i < 8; i++) step1(0, 8, i);
        for (int i = 0; i < 8; i++) step1(0, 8, i);
        en_v[0] = 1'b0;
        idle();

        // Channel 1: divisors 1 and 0 behave as 2.
        tid = 5;
        ld_v[1] = 1'b1;
        dv_v[1] = 16'd3;
        idle();
        dv_v[1] = 16'd1;
        idle();
        ld_v[1] = 1'b0;
        en_v[1] = 1'b1;
        for (int i = 0; i < 4; i++) step1(1, 2, i % 2);
        en_v[1] = 1'b0;
        idle();
        ld_v[1] = 1'b1;
        dv_v[1] = 16'd0;
        idle();
        ld_v[1] = 1'b0;
        en_v[1] = 1'b1;
        step1(1, 2, 0);
        step1(1, 2, 1);
        en_v[1] = 1'b0;
        idle();

        // Channel 3: maximum divisor 65535.
        tid = 6;
        ld_v[3] = 1'b1;
        dv_v[3] = 16'hFFFF;
        idle();
        ld_v[3] = 1'b0;
        en_v[3] = 1'b1;
        for (int i = 0; i < 65535; i++) step1(3, 65535, i);
        en_v[3] = 1'b0;
        idle();

        // Channels 2 (D=3) and 3 (D=7, pending 5) out of phase, then sync on ch2's wrap.
        tid = 7;
        ld_v[3] = 1'b1;
        dv_v[3] = 16'd7;
        idle();
        ld_v[3] = 1'b0;
        en_v[2] = 1'b1;
        step1(2, 3, 0);
        en_v[3] = 1'b1;
        step2(3, 1, 7, 0);
        ld_v[3] = 1'b1;
        dv_v[3] = 16'd5;
        step2(3, 2, 7, 1);
        ld_v[3] = 1'b0;
        sync_v  = 1'b1;
        step2(3, 0, 5, 0);
        sync_v  = 1'b0;
        for (int i = 1; i <= 32; i++) step2(3, i % 3, 5, i % 5);

        // Reset mid-period restores the default divisor; sync with enable low stops a channel.
        tid = 8;
        rst_v = 1'b1;
        idle();
        rst_v   = 1'b0;
        en_v[2] = 1'b0;
        en_v[3] = 1'b1;
        step1(3, 2, 0);
        step1(3, 2, 1);
        step1(3, 2, 0);
        en_v[3] = 1'b0;
        sync_v  = 1'b1;
        idle();
        sync_v  = 1'b0;
        idle();

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected pending=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_divider_n.md
Name: clock_divider_n

Overview:
Synthesizable, multi-channel programmable clock divider driven from the single system clock.
- Each channel produces a divided square wave (clk_out) and a one-cycle end-of-period strobe (tick).
- Divisor changes and enable changes are glitch-free: they take effect only at period boundaries.
- Replaces behavioural fixed-frequency clock sources with a parametrised RTL block; feeds baud generators, LED blinkers and slow-peripheral strobes.

Parameters:
CHANNELS, 4, number of independent divider channels
DIV_W, 16, width of each channel's divisor
DEFAULT_DIV, 2, divisor loaded into every channel at reset (clamped to >=2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  CHANNELS  per-channel run request
div_load  input  CHANNELS  per-channel strobe: capture that channel's slice of div_value as pending divisor
div_value  input  CHANNELS*DIV_W  divisor values; channel k uses bits [k*DIV_W +: DIV_W]
sync  input  1  restart all running channels at period start simultaneously
clk_out  output  CHANNELS  divided clock, registered
tick  output  CHANNELS  one-cycle pulse in last cycle of each period, registered
active  output  CHANNELS  channel is in RUN

Behaviour:
- Reset (rst=1 at an edge), per channel:
  - state=IDLE, cnt=0.
  - D=DEFAULT_DIV, pending P=DEFAULT_DIV, pend_valid=0.
  - clk_out=0, tick=0, active=0.
  - rst overrides every other input.
- Divisor clamp: any value 0 or 1 (at reset, load or apply) is stored as 2. Max divisor 2^DIV_W-1.
- Waveform in RUN: period is exactly D cycles.
  - clk_out=1 while cnt < floor(D/2), else 0.
  - Odd D gives the shorter high phase (D=3: 1 high, 2 low).
  - tick=1 only in the cycle where cnt==D-1.
- Per-channel FSM, IDLE / RUN:
  - IDLE: outputs 0, cnt held 0.
    - enable=1 sampled -> RUN, cnt=0.
    - clk_out rises 1 cycle after enable is sampled.
    - Any pending divisor is applied on this same edge.
  - RUN, cnt != D-1: cnt <= cnt+1.
  - RUN, cnt == D-1 (wrap edge): cnt <= 0.
    - If pend_valid: D <= P, pend_valid <= 0.
    - If enable=0: -> IDLE, clk_out and tick are 0 from the next cycle.
    - Otherwise stay in RUN with the new D.
  - enable is ignored mid-period, so no truncated pulse is ever emitted. Deasserting then reasserting enable before the wrap leaves the channel running without interruption.
- div_load:
  - Captures the clamped value into P and sets pend_valid=1.
  - In IDLE, D is also updated on the same edge.
  - A later load before the wrap overwrites P; last value wins.
  - Load on the wrap edge itself: the new value is applied at the *next* wrap. The old P is applied on the current wrap.
- sync=1 at an edge: every channel in RUN sets cnt <= 0 and applies any pending P immediately.
  - clk_out of all running channels goes high together on the following cycle.
  - A channel whose enable=0 on a sync edge goes to IDLE instead (sync acts as a forced boundary).
  - IDLE channels are unaffected.
  - sync on a cycle where a channel also wraps is treated as one boundary: no double tick.
- Channels are fully independent except for the shared sync.
- Counter width is DIV_W and never exceeds D-1.

Test Plan:
- Reset then enable[0]=1 with default D=2 -> clk_out[0] toggles 1,0,1,0 starting 1 cycle after enable; tick[0]=1 on every cycle where clk_out[0]=0; active[0]=1.
- div_load[1] with 5 while IDLE, then enable -> period 5: clk_out 1,1,0,0,0 repeating; tick high on 5th cycle only.
- Channel 2 running D=4; load 6 at cnt=1 -> remaining period completes at 4 cycles, then 6-cycle periods; no period of other length.
- Channel 0 running D=8; drop enable at cnt=2 -> runs to cnt=7 with tick, then clk_out/tick/active=0; reassert enable before cnt=7 -> no interruption.
- Load 0 and 1 -> behaves as D=2; load 65535 (DIV_W=16) -> high 32767 cycles, low 32768.
- Channels D=3 and D=5 running out of phase; pulse sync -> both clk_out high on the next cycle and aligned; the 15-cycle LCM pattern repeats thereafter. Assert rst mid-period -> all outputs 0 next cycle, D=DEFAULT_DIV.
